// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pkg
// Brief    : Shared register-file widths and the writeback request record.
// Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Brief    : Small writeback FIFO exposing per-entry addresses for hazard query.
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push_i,
    input  wb_req_t                      push_data_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         empty_o,
    output wb_req_t                      head_o,
    output logic [DEPTH-1:0]             ent_valid_o,
    output logic [DEPTH-1:0][ADDR_W-1:0] ent_addr_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] offset;
    logic             do_push;
    logic             do_pop;
    wb_req_t          mem_q [DEPTH];
    wb_req_t          mem_d [DEPTH];

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_data_i;
        end
    end

    always_comb begin
        offset      = '0;
        ent_valid_o = '0;
        ent_addr_o  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PTR_W'(i) - rd_ptr_q[PTR_W-1:0];
            ent_valid_o[i] = ({1'b0, offset} < count);
            ent_addr_o[i]  = mem_q[i].addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Brief    : Shares the register-file write port between pipeline writeback
//            and buffered long-latency results, with starvation stall.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
    import rv_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_data_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_data_i,
    input  logic [ADDR_W-1:0] q_addr_i,
    output logic              q_hit_o,
    output logic              stall_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o
);

    localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic                         fifo_full;
    logic                         fifo_empty;
    wb_req_t                      fifo_head;
    logic [DEPTH-1:0]             ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic                         push;
    logic                         pop;
    logic                         a_req;
    logic                         hit;

    logic              rf_we_q,    rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              stall_q,    stall_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    assign b_ready_o = reset_n && !fifo_full;
    // Writes to x0 complete the handshake but are dropped here.
    assign push      = b_valid_i && b_ready_o && (b_addr_i != '0);
    assign a_req     = a_valid_i && (a_addr_i != '0);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i ('{addr: b_addr_i, data: b_data_i}),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head),
        .ent_valid_o (ent_valid),
        .ent_addr_o  (ent_addr)
    );

    always_comb begin
        pop        = 1'b0;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        cnt_d      = cnt_q;
        if (stall_q) begin
            cnt_d = '0;
            if (!fifo_empty) begin
                pop        = 1'b1;
                rf_we_d    = 1'b1;
                rf_waddr_d = fifo_head.addr;
                rf_wdata_d = fifo_head.data;
            end
        end else if (a_req) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = a_addr_i;
            rf_wdata_d = a_data_i;
            if (!fifo_empty && (cnt_q < LIMIT)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!fifo_empty) begin
            pop        = 1'b1;
            rf_we_d    = 1'b1;
            rf_waddr_d = fifo_head.addr;
            rf_wdata_d = fifo_head.data;
            cnt_d      = '0;
        end
        stall_d = (cnt_d == LIMIT);
    end

    // The head being popped this cycle is still a pending write.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == q_addr_i)) begin
                hit = 1'b1;
            end
        end
    end

    assign q_hit_o = hit && (q_addr_i != '0) && reset_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            stall_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            stall_q    <= stall_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign stall_o    = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_arbiter
// Brief    : Directed stimulus with a write scoreboard for rf_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;
    import rv_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              a_valid_i;
    logic [ADDR_W-1:0] a_addr_i;
    logic [DATA_W-1:0] a_data_i;
    logic              b_valid_i;
    logic              b_ready_o;
    logic [ADDR_W-1:0] b_addr_i;
    logic [DATA_W-1:0] b_data_i;
    logic [ADDR_W-1:0] q_addr_i;
    logic              q_hit_o;
    logic              stall_o;
    logic              rf_we_o;
    logic [ADDR_W-1:0] rf_waddr_o;
    logic [DATA_W-1:0] rf_wdata_o;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    rf_write_arbiter #(
        .DEPTH        (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .a_valid_i  (a_valid_i),
        .a_addr_i   (a_addr_i),
        .a_data_i   (a_data_i),
        .b_valid_i  (b_valid_i),
        .b_ready_o  (b_ready_o),
        .b_addr_i   (b_addr_i),
        .b_data_i   (b_data_i),
        .q_addr_i   (q_addr_i),
        .q_hit_o    (q_hit_o),
        .stall_o    (stall_o),
        .rf_we_o    (rf_we_o),
        .rf_waddr_o (rf_waddr_o),
        .rf_wdata_o (rf_wdata_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, req);
        end
    endtask

    task automatic set_in(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                          input bit bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
        a_valid_i = av; a_addr_i = aa; a_data_i = ad;
        b_valid_i = bv; b_addr_i = ba; b_data_i = bd;
    endtask

    task automatic expect_wr(input int c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        e.cyc = c; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(0, 0, 0, 0, 0, 0);
            adv();
        end
    endtask

    // Monitor: every cycle either the scheduled write appears or nothing is written.
    always @(negedge clk) begin
        if (mon_en) begin
            if (reset_n && stall_o && a_valid_i) begin
                checks++;
                errors++;
                $display("FAIL contract: a_valid_i=1 while stall_o=1 at cycle %0d", cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_we",   rf_we_o,    1);
                chk("wr_addr", rf_waddr_o, e.addr);
                chk("wr_data", rf_wdata_o, e.data);
            end else begin
                chk("no_write", rf_we_o, 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        q_addr_i = '0;
        set_in(0, 0, 0, 1, 5'd3, 32'h55);

        // Reset held across two edges with B offering data.
        adv();
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", b_ready_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_waddr", rf_waddr_o, 0);
        chk("rst_wdata", rf_wdata_o, 0);
        adv();
        @(negedge clk);
        chk("rst_ready2", b_ready_o, 0);
        chk("rst_stall2", stall_o, 0);
        adv();
        reset_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("ready_after_rst", b_ready_o, 1);
        adv();

        // A only, then a write to x0 that must be ignored.
        set_in(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        expect_wr(cyc + 1, 5'd5, 32'hDEADBEEF);
        adv();
        set_in(1, 5'd0, 32'h1234, 0, 0, 0);
        adv();
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("hold_waddr", rf_waddr_o, 5);
        chk("hold_wdata", rf_wdata_o, 32'hDEADBEEF);
        adv();

        // B only: two back-to-back results then a discarded x0 result.
        set_in(0, 0, 0, 1, 5'd7, 32'h11);
        expect_wr(cyc + 2, 5'd7, 32'h11);
        @(negedge clk); chk("b_ready_x7", b_ready_o, 1);
        adv();
        set_in(0, 0, 0, 1, 5'd8, 32'h22);
        expect_wr(cyc + 2, 5'd8, 32'h22);
        @(negedge clk); chk("b_ready_x8", b_ready_o, 1);
        adv();
        set_in(0, 0, 0, 1, 5'd0, 32'h33);
        @(negedge clk); chk("b_ready_x0", b_ready_o, 1);
        adv();
        idle(3);

        // Backpressure: A streams while B offers three results.
        set_in(1, 5'd1, 32'hA0, 1, 5'd10, 32'hB0);
        expect_wr(cyc + 1, 5'd1, 32'hA0);
        @(negedge clk); chk("bp_ready0", b_ready_o, 1);
        adv();
        set_in(1, 5'd2, 32'hA1, 1, 5'd11, 32'hB1);
        expect_wr(cyc + 1, 5'd2, 32'hA1);
        @(negedge clk); chk("bp_ready1", b_ready_o, 1);
        adv();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 5'(3 + k), 32'hA2 + k, 1, 5'd13, 32'hB2);
            expect_wr(cyc + 1, 5'(3 + k), 32'hA2 + k);
            @(negedge clk);
            chk("bp_full_ready", b_ready_o, 0);
            chk("bp_no_stall", stall_o, 0);
            adv();
        end
        set_in(0, 0, 0, 1, 5'd13, 32'hB2);
        expect_wr(cyc + 1, 5'd10, 32'hB0);
        @(negedge clk);
        chk("bp_stall", stall_o, 1);
        chk("bp_stall_ready", b_ready_o, 0);
        adv();
        expect_wr(cyc + 1, 5'd11, 32'hB1);
        expect_wr(cyc + 2, 5'd13, 32'hB2);
        @(negedge clk);
        chk("bp_unstall", stall_o, 0);
        chk("bp_third_ready", b_ready_o, 1);
        adv();
        idle(3);

        // Starvation: x9 buffered while A wins four consecutive cycles.
        set_in(1, 5'd20, 32'hC0, 1, 5'd9, 32'h99);
        expect_wr(cyc + 1, 5'd20, 32'hC0);
        adv();
        for (int k = 0; k < 4; k++) begin
            set_in(1, 5'(21 + k), 32'hD1 + k, 0, 0, 0);
            expect_wr(cyc + 1, 5'(21 + k), 32'hD1 + k);
            @(negedge clk); chk("starve_no_stall", stall_o, 0);
            adv();
        end
        set_in(0, 0, 0, 0, 0, 0);
        expect_wr(cyc + 1, 5'd9, 32'h99);
        @(negedge clk); chk("starve_stall", stall_o, 1);
        adv();
        @(negedge clk); chk("starve_release", stall_o, 0);
        adv();
        @(negedge clk); chk("starve_stays_low", stall_o, 0);
        adv();

        // Hazard query on a buffered x12.
        set_in(1, 5'd25, 32'h250, 1, 5'd12, 32'h12C);
        expect_wr(cyc + 1, 5'd25, 32'h250);
        q_addr_i = 5'd12;
        @(negedge clk); chk("hit_before_enq", q_hit_o, 0);
        adv();
        set_in(1, 5'd26, 32'h260, 0, 0, 0);
        expect_wr(cyc + 1, 5'd26, 32'h260);
        @(negedge clk); chk("hit_x12", q_hit_o, 1);
        q_addr_i = 5'd13; #1; chk("hit_x13", q_hit_o, 0);
        q_addr_i = 5'd0;  #1; chk("hit_x0", q_hit_o, 0);
        adv();
        set_in(0, 0, 0, 0, 0, 0);
        expect_wr(cyc + 1, 5'd12, 32'h12C);
        q_addr_i = 5'd12;
        @(negedge clk); chk("hit_while_pop", q_hit_o, 1);
        adv();
        @(negedge clk); chk("hit_after_retire", q_hit_o, 0);
        adv();

        // Reset mid-operation drops the buffered x14.
        set_in(1, 5'd27, 32'h270, 1, 5'd14, 32'h140);
        expect_wr(cyc + 1, 5'd27, 32'h270);
        q_addr_i = 5'd14;
        adv();
        reset_n = 1'b0;
        set_in(1, 5'd28, 32'h280, 0, 0, 0);
        @(negedge clk);
        chk("midrst_ready", b_ready_o, 0);
        chk("midrst_hit", q_hit_o, 0);
        adv();
        reset_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst_flushed", q_hit_o, 0);
        chk("midrst_waddr", rf_waddr_o, 0);
        adv();
        idle(4);

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
